// File: rtl/pipe_mult_pkg.sv
// Shared constants, width helpers and the per-stage control record for
// pipelined_mult_array. The PIPE_MULT_ACC_EN build also uses the clr bit.
package pipe_mult_pkg;

  localparam int unsigned NUM_STAGES = 4;

  // Width of one operand half used by the quarter-product split.
  function automatic int unsigned HALF(input int unsigned width);
    return width / 2;
  endfunction

  // Width of the full product.
  function automatic int unsigned PROD_W(input int unsigned width);
    return 2 * width;
  endfunction

  // Control fields carried with every in-flight operation. The valid bit lives
  // in each stage slice; tag and payload are packed alongside these fields.
  typedef struct packed {
    logic neg;          // final product must be negated
    logic signed_mode;  // operands were two's complement
    logic clr;          // restart the accumulator on this op
  } stage_ctrl_t;

endpackage

// File: rtl/pipelined_mult_array_if.sv
// Operand/result handshake bundle for pipelined_mult_array.
// PIPE_MULT_ACC_EN adds acc_clear and out_acc.
interface pipelined_mult_array_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAG_WIDTH = 4
`ifdef PIPE_MULT_ACC_EN
  ,
  parameter int unsigned ACC_GUARD = 4
`endif
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_signed;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     out_product;
  logic [TAG_WIDTH-1:0]   out_tag;
`ifdef PIPE_MULT_ACC_EN
  logic                         acc_clear;
  logic [2*WIDTH+ACC_GUARD-1:0] out_acc;
`endif

  // Producer/consumer side.
  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
`ifdef PIPE_MULT_ACC_EN
    output acc_clear,
    input  out_acc,
`endif
    input  in_ready, out_valid, out_product, out_tag
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
`ifdef PIPE_MULT_ACC_EN
    input  acc_clear,
    output out_acc,
`endif
    output in_ready, out_valid, out_product, out_tag
  );

endinterface

// File: rtl/mult_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when the next stage
// loads, so bubbles are filled even while downstream is stalled.
module mult_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  input  logic             next_load_i,
  output logic             load_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  assign load_o  = !valid_q || next_load_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next state: take the upstream slot on load; payload only changes on real data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // Slice registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipelined_mult_array.sv
// Four-stage signed/unsigned multiplier built from quarter partial products,
// with valid/ready flow control and a pass-through tag.
// Optional accumulator enabled by PIPE_MULT_ACC_EN.
module pipelined_mult_array
  import pipe_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned ACC_GUARD = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_mult_array_if.slave bus
);

  localparam int unsigned H    = HALF(WIDTH);
  localparam int unsigned P    = PROD_W(WIDTH);
  localparam int unsigned CW   = $bits(stage_ctrl_t);
  localparam int unsigned S1W  = CW + TAG_WIDTH + 2 * WIDTH;
  localparam int unsigned S2W  = CW + TAG_WIDTH + 4 * WIDTH;
  localparam int unsigned S34W = CW + TAG_WIDTH + P;

  logic [NUM_STAGES-1:0] st_valid;
  logic [NUM_STAGES-1:0] st_valid_in;
  logic                  s1_load, s2_load, s3_load, s4_load;

  assign st_valid_in = {st_valid[NUM_STAGES-2:0], bus.in_valid};
  assign bus.in_ready = s1_load;

  // ---- S1: operand magnitudes and sign ----
  stage_ctrl_t          s1_ctrl_d, s1_ctrl;
  logic [WIDTH-1:0]     abs_a, abs_b, s1_a, s1_b;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [S1W-1:0]       s1_q;

  // Magnitudes; -2^(WIDTH-1) maps onto 2^(WIDTH-1), still representable unsigned.
  always_comb begin
    abs_a = bus.in_a;
    abs_b = bus.in_b;
    if (bus.in_signed && bus.in_a[WIDTH-1]) abs_a = -bus.in_a;
    if (bus.in_signed && bus.in_b[WIDTH-1]) abs_b = -bus.in_b;
    s1_ctrl_d.neg         = bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
    s1_ctrl_d.signed_mode = bus.in_signed;
`ifdef PIPE_MULT_ACC_EN
    s1_ctrl_d.clr         = bus.acc_clear;
`else
    s1_ctrl_d.clr         = 1'b0;
`endif
  end

  mult_pipe_stage #(.Width(S1W)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (st_valid_in[0]),
    .data_i     ({s1_ctrl_d, bus.in_tag, abs_a, abs_b}),
    .next_load_i(s2_load),
    .load_o     (s1_load),
    .valid_o    (st_valid[0]),
    .data_o     (s1_q)
  );
  assign {s1_ctrl, s1_tag, s1_a, s1_b} = s1_q;

  // ---- S2: quarter partial products ----
  stage_ctrl_t          s2_ctrl;
  logic [TAG_WIDTH-1:0] s2_tag;
  logic [WIDTH-1:0]     pp_ll, pp_lh, pp_hl, pp_hh;
  logic [WIDTH-1:0]     s2_ll, s2_lh, s2_hl, s2_hh;
  logic [WIDTH-1:0]     al, ah, bl, bh;
  logic [S2W-1:0]       s2_q;

  // Halves zero-extended to WIDTH so each product keeps all of its bits.
  always_comb begin
    al    = {{H{1'b0}}, s1_a[H-1:0]};
    ah    = {{H{1'b0}}, s1_a[WIDTH-1:H]};
    bl    = {{H{1'b0}}, s1_b[H-1:0]};
    bh    = {{H{1'b0}}, s1_b[WIDTH-1:H]};
    pp_ll = al * bl;
    pp_lh = al * bh;
    pp_hl = ah * bl;
    pp_hh = ah * bh;
  end

  mult_pipe_stage #(.Width(S2W)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (st_valid_in[1]),
    .data_i     ({s1_ctrl, s1_tag, pp_hh, pp_hl, pp_lh, pp_ll}),
    .next_load_i(s3_load),
    .load_o     (s2_load),
    .valid_o    (st_valid[1]),
    .data_o     (s2_q)
  );
  assign {s2_ctrl, s2_tag, s2_hh, s2_hl, s2_lh, s2_ll} = s2_q;

  // ---- S3: magnitude summation ----
  stage_ctrl_t          s3_ctrl;
  logic [TAG_WIDTH-1:0] s3_tag;
  logic [WIDTH:0]       mid_sum;
  logic [P:0]           mag_full;
  logic [P-1:0]         s3_mag;
  logic [S34W-1:0]      s3_q;

  // Sum at P+1 bits so the LH+HL carry is never dropped.
  always_comb begin
    mid_sum  = {1'b0, s2_lh} + {1'b0, s2_hl};
    mag_full = {1'b0, s2_hh, {WIDTH{1'b0}}}
             + {{(WIDTH-H){1'b0}}, mid_sum, {H{1'b0}}}
             + {{(WIDTH+1){1'b0}}, s2_ll};
  end

  mult_pipe_stage #(.Width(S34W)) u_s3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (st_valid_in[2]),
    .data_i     ({s2_ctrl, s2_tag, mag_full[P-1:0]}),
    .next_load_i(s4_load),
    .load_o     (s3_load),
    .valid_o    (st_valid[2]),
    .data_o     (s3_q)
  );
  assign {s3_ctrl, s3_tag, s3_mag} = s3_q;

  // ---- S4: sign restore and output register ----
  stage_ctrl_t          s4_ctrl;
  logic [P-1:0]         prod_d, s4_prod;
  logic [TAG_WIDTH-1:0] s4_tag;
  logic [S34W-1:0]      s4_q;

  // Two's-complement negate when exactly one signed operand was negative.
  always_comb begin
    prod_d = s3_ctrl.neg ? -s3_mag : s3_mag;
  end

  mult_pipe_stage #(.Width(S34W)) u_s4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (st_valid_in[3]),
    .data_i     ({s3_ctrl, s3_tag, prod_d}),
    .next_load_i(bus.out_ready),
    .load_o     (s4_load),
    .valid_o    (st_valid[3]),
    .data_o     (s4_q)
  );
  assign {s4_ctrl, s4_tag, s4_prod} = s4_q;

  assign bus.out_valid   = st_valid[3];
  assign bus.out_product = s4_prod;
  assign bus.out_tag     = s4_tag;

  logic unused_bits;
  assign unused_bits = ^{s4_ctrl, mag_full[P]};

`ifdef PIPE_MULT_ACC_EN
  localparam int unsigned AccW = P + ACC_GUARD;
  logic [AccW-1:0] acc_d, acc_q, prod_ext;

  // Accumulate on each output transfer; unsigned results are zero-extended.
  always_comb begin
    prod_ext = {{ACC_GUARD{1'b0}}, s4_prod};
    if (s4_ctrl.signed_mode) prod_ext = {{ACC_GUARD{s4_prod[P-1]}}, s4_prod};
    acc_d = acc_q;
    if (st_valid[3] && bus.out_ready) acc_d = (s4_ctrl.clr ? '0 : acc_q) + prod_ext;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign bus.out_acc = acc_q;
`else
  logic [ACC_GUARD-1:0] unused_guard;
  assign unused_guard = '0;
`endif

endmodule

// File: tb/tb_pipelined_mult_array.sv
// Self-checking bench for pipelined_mult_array (WIDTH=8). Covers the
// PIPE_MULT_ACC_EN accumulator when that macro is defined.
module tb_pipelined_mult_array;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned AG = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_mult_array_if #(
    .WIDTH    (W),
    .TAG_WIDTH(TW)
`ifdef PIPE_MULT_ACC_EN
    ,
    .ACC_GUARD(AG)
`endif
  ) bus ();

  pipelined_mult_array #(
    .WIDTH    (W),
    .TAG_WIDTH(TW),
    .ACC_GUARD(AG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [2*W-1:0] prod;
    logic [TW-1:0]  tag;
    bit             s;
    bit             clr;
  } exp_t;

  exp_t           exp_q[$];
  int             n_checks = 0;
  int             n_pass   = 0;
  int             n_fail   = 0;
  bit             stall_prev = 0;
  logic [2*W-1:0] held_prod;
  logic [TW-1:0]  held_tag;
  bit             s_in_ready, s_out_valid, in_xfer, out_xfer;
  logic [2*W-1:0] s_product;
  logic [TW-1:0]  s_tag;
  longint         model_acc = 0;
  bit             acc_pending = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference product straight from integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint     x, y;
    logic [63:0] p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  task automatic set_op(input bit v, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input bit clr);
    bus.in_valid  = v;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
`ifdef PIPE_MULT_ACC_EN
    bus.acc_clear = clr;
`else
    if (clr) bus.in_tag = tag;
`endif
  endtask

  // One cycle: sample after inputs settle, score transfers, advance to next negedge.
  task automatic tick();
    exp_t e;
    longint ext;
    #1;
`ifdef PIPE_MULT_ACC_EN
    if (acc_pending) chk("out_acc", bus.out_acc, model_acc[2*W+AG-1:0]);
`endif
    acc_pending = 0;
    if (stall_prev) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_product", bus.out_product, held_prod);
      chk("stall_tag", bus.out_tag, held_tag);
    end
    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_product   = bus.out_product;
    s_tag       = bus.out_tag;
    out_xfer    = bus.out_valid && bus.out_ready;
    in_xfer     = bus.in_valid && bus.in_ready;
    stall_prev  = bus.out_valid && !bus.out_ready;
    held_prod   = bus.out_product;
    held_tag    = bus.out_tag;
    if (out_xfer) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_product", bus.out_product, e.prod);
        chk("sb_tag", bus.out_tag, e.tag);
        ext = e.s ? longint'($signed(e.prod)) : longint'(e.prod);
        model_acc = ((e.clr ? 64'sd0 : model_acc) + ext) & ((64'sd1 <<< (2*W+AG)) - 1);
        acc_pending = 1;
      end
    end
    if (in_xfer) begin
      e.prod = ref_mul(bus.in_signed, bus.in_a, bus.in_b);
      e.tag  = bus.in_tag;
      e.s    = bus.in_signed;
`ifdef PIPE_MULT_ACC_EN
      e.clr  = bus.acc_clear;
`else
      e.clr  = 1'b0;
`endif
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic single_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [TW-1:0] tag, input logic [2*W-1:0] exp_p);
    int lat;
    lat = 0;
    set_op(1, s, a, b, tag, 0);
    tick();
    chk("single_accept", in_xfer, 1);
    bus.in_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (s_out_valid) begin
        lat = k;
        break;
      end
    end
    chk("single_latency", lat, 4);
    chk("single_product", s_product, exp_p);
    chk("single_tag", s_tag, tag);
  endtask

  initial begin
    int idx, first_block, delivered, vcount, acc_cnt, cyc;
    set_op(0, 0, '0, '0, '0, 0);
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_product", bus.out_product, 0);
    chk("rst_out_tag", bus.out_tag, 0);
`ifdef PIPE_MULT_ACC_EN
    chk("rst_out_acc", bus.out_acc, 0);
`endif
    @(negedge clk);

    // Directed corner products.
    single_op(1, 8'h80, 8'h80, 4'hA, 16'h4000);
    single_op(1, 8'hFD, 8'h05, 4'h3, 16'hFFF1);
    single_op(0, 8'hFD, 8'h05, 4'h5, 16'h04F1);
    single_op(0, 8'hFF, 8'hFF, 4'h6, 16'hFE01);
    single_op(1, 8'hFF, 8'hFF, 4'h9, 16'h0001);

    // Backpressure: tags 0..9 streamed, consumer stalls for 6 cycles from cycle 3.
    idx = 0;
    first_block = -1;
    delivered = 0;
    for (int c = 0; c < 60 && (idx < 10 || exp_q.size() != 0); c++) begin
      if (idx < 10) set_op(1, c[0], 8'(idx * 17 + 3), 8'(idx * 5 + 1), 4'(idx), 0);
      else bus.in_valid = 0;
      bus.out_ready = !(c >= 3 && c < 9);
      tick();
      if (!s_in_ready && first_block < 0) first_block = idx;
      if (in_xfer) idx++;
      if (out_xfer) delivered++;
    end
    chk("bp_accepted_before_stall", first_block, 4);
    chk("bp_delivered", delivered, 10);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset with three operations in flight.
    bus.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      set_op(1, 0, 8'(k + 7), 8'(k + 9), 4'(k + 1), 0);
      tick();
    end
    bus.in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_product", bus.out_product, 0);
    chk("midrst_out_tag", bus.out_tag, 0);
`ifdef PIPE_MULT_ACC_EN
    chk("midrst_out_acc", bus.out_acc, 0);
`endif
    exp_q.delete();
    stall_prev  = 0;
    acc_pending = 0;
    model_acc   = 0;
    @(negedge clk);
    rst_n = 1;
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_out_valid) vcount++;
    end
    chk("midrst_no_ghosts", vcount, 0);

`ifdef PIPE_MULT_ACC_EN
    // Accumulator: -15, +100, +16384 with a clear on the first.
    set_op(1, 1, 8'hFD, 8'h05, 4'h0, 1);
    tick();
    set_op(1, 1, 8'h0A, 8'h0A, 4'h1, 0);
    tick();
    set_op(1, 1, 8'h80, 8'h80, 4'h2, 0);
    tick();
    bus.in_valid = 0;
    repeat (6) tick();
    chk("acc_directed_final", bus.out_acc, 20'd16469);
`endif

    // Random traffic against the reference model.
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      set_op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
             8'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
      if (in_xfer) acc_cnt++;
      cyc++;
    end
    bus.in_valid  = 0;
    bus.out_ready = 1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    chk("rnd_accepted", acc_cnt, 1000);
    chk("rnd_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
